// File: rtl/nyq_upsampler.sv
// nyq_upsampler: zero-stuffing symbol upsampler feeding the NYQ sample input.
// Symbols enter a small FIFO; one is emitted every OSR cycles with zeros between.
module nyq_upsampler #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic                  Sym_Valid_SI,
    output logic                  Sym_Ready_SO,
    input  logic [IN_WIDTH-1:0]   Sym_In_DI,
    output logic [OUT_WIDTH-1:0]  UPS_Out_DO,
    output logic                  Undr_SO
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [IN_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [4:0]          osr_shadow, osr, osr_eff, phase;
    logic                en, push, pop, starve, wr_osr, wr_en, wr_clr, osr_ok, unused_par;

    assign wr_osr       = WrEn_SI && Addr_DI == ADDR_WIDTH'(0);
    assign wr_en        = WrEn_SI && Addr_DI == ADDR_WIDTH'(1);
    assign wr_clr       = WrEn_SI && Addr_DI == ADDR_WIDTH'(2);
    assign osr_ok       = PAR_In_DI[4:0] >= 5'd2 && PAR_In_DI[4:0] <= 5'd16;
    assign unused_par   = ^PAR_In_DI[MEM_WIDTH-1:5];
    assign Sym_Ready_SO = count < CW'(FIFO_DEPTH) && !Rst_RI;
    assign push         = Sym_Valid_SI && Sym_Ready_SO;
    assign pop          = en && phase == '0 && count != '0;
    assign starve       = en && phase == '0 && count == '0;
    // A new OSR only takes effect at a period boundary, so periods never mix lengths.
    assign osr_eff      = (phase == '0 || !en) ? osr_shadow : osr;

    always_ff @(posedge Clk_CI) begin
        if (push)
            mem[wr_ptr] <= Sym_In_DI;
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            osr_shadow <= 5'd4;
            osr        <= 5'd4;
            en         <= 1'b0;
            phase      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            UPS_Out_DO <= '0;
            Undr_SO    <= 1'b0;
        end else begin
            if (wr_osr && osr_ok)
                osr_shadow <= PAR_In_DI[4:0];
            if (wr_en)
                en <= PAR_In_DI[0];
            osr   <= osr_eff;
            phase <= (en && phase != osr_eff - 5'd1) ? phase + 5'd1 : 5'd0;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count      <= count + CW'(push) - CW'(pop);
            UPS_Out_DO <= pop ? OUT_WIDTH'($signed(mem[rd_ptr])) : '0;
            // A fresh underrun beats a simultaneous clear.
            Undr_SO    <= starve || (Undr_SO && !wr_clr);
        end
    end
endmodule
